// File: rtl/serial_transmitter_if.sv
// serial_transmitter_if
//   Handshake and data bundle between the link controller (master) and the
//   serializing back-end (slave).
//   Load        : controller -> tx, one-cycle capture strobe for data_in
//   Transmit    : controller -> tx, level held while waiting for Transmitted
//   data_in     : controller -> tx, parallel word from the collect stage
//   Transmitted : tx -> controller, one-cycle frame-done pulse
//   serial_out  : tx -> line, registered serial output, idle high
//   busy        : tx -> controller, high whenever the transmitter is not idle
interface serial_transmitter_if #(
    parameter int DATA_W = 8
);
    logic              Load;
    logic              Transmit;
    logic [DATA_W-1:0] data_in;
    logic              Transmitted;
    logic              serial_out;
    logic              busy;

    modport master (
        output Load, Transmit, data_in,
        input  Transmitted, serial_out, busy
    );

    modport slave (
        input  Load, Transmit, data_in,
        output Transmitted, serial_out, busy
    );
endinterface

// File: rtl/serial_transmitter.sv
// serial_transmitter
//   Captures a parallel word on Load and, while Transmit is high, shifts out
//   a framed character: start bit, DATA_W data bits LSB first, optional even
//   parity bit, stop bit. Each bit lasts DIV clocks. A one-cycle Transmitted
//   pulse closes the frame.
//   Ports:
//     clk : system clock, rising edge
//     rst : asynchronous active-low reset
//     bus : serial_transmitter_if slave modport (Load, Transmit, data_in in;
//           Transmitted, serial_out, busy out)
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   S_IDLE   | line high, waiting for Transmit with a word loaded
//   S_START  | start bit (0) for DIV cycles
//   S_DATA   | DATA_W data bits, LSB first, DIV cycles each
//   S_PARITY | even parity bit for DIV cycles (PARITY_EN only)
//   S_STOP   | stop bit (1) for DIV cycles
//   S_DONE   | single cycle, Transmitted pulse
module serial_transmitter #(
    parameter int DATA_W    = 8,
    parameter int DIV       = 4,
    parameter int PARITY_EN = 1
) (
    input logic                 clk,
    input logic                 rst,
    serial_transmitter_if.slave bus
);
    localparam int BAUD_W = $clog2(DIV);
    localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [BAUD_W-1:0]   r_baud;
    logic [BIT_W-1:0]    r_bit;
    logic [DATA_W-1:0]   r_hold;
    logic                r_loaded;
    logic [DATA_W-1:0]   r_shift;
    logic                r_parity;
    logic                r_serial_out;

    logic                w_wrap;
    logic                w_last_bit;
    logic                w_start;
    logic                w_timed;
    logic [DATA_W-1:0]   w_shift_next;
    logic                w_serial_next;
    logic                w_transmitted;
    logic                w_busy;

    assign w_wrap       = (r_baud == BAUD_W'(DIV - 1));
    assign w_last_bit   = (r_bit == BIT_W'(DATA_W - 1));
    assign w_start      = (r_state == S_IDLE) && (w_state_next == S_START);
    assign w_timed      = (r_state == S_START) || (r_state == S_DATA) ||
                          (r_state == S_PARITY) || (r_state == S_STOP);
    assign w_shift_next = r_shift >> 1;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.Transmit && r_loaded) w_state_next = S_START;
            S_START:  if (w_wrap) w_state_next = S_DATA;
            S_DATA:   if (w_wrap && w_last_bit)
                          w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (w_wrap) w_state_next = S_STOP;
            S_STOP:   if (w_wrap) w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Output logic. serial_out is registered, so the line value is derived
    // from the state being entered; this puts the start bit on the line in
    // the first cycle of S_START rather than one cycle late.
    always_comb begin
        w_serial_next = 1'b1;
        case (w_state_next)
            S_START:  w_serial_next = 1'b0;
            S_DATA:   w_serial_next = (r_state == S_DATA && w_wrap) ?
                                      w_shift_next[0] : r_shift[0];
            S_PARITY: w_serial_next = r_parity;
            default:  w_serial_next = 1'b1;
        endcase
        w_transmitted = (r_state == S_DONE);
        w_busy        = (r_state != S_IDLE);
    end

    // Datapath: holding register, shift register, counters, line register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_baud       <= '0;
            r_bit        <= '0;
            r_hold       <= '0;
            r_loaded     <= 1'b0;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_serial_out <= 1'b1;
        end else begin
            r_serial_out <= w_serial_next;

            if (w_timed && !w_wrap) begin
                r_baud <= r_baud + BAUD_W'(1);
            end else begin
                r_baud <= '0;
            end

            if (r_state == S_DATA) begin
                if (w_wrap) begin
                    r_bit <= w_last_bit ? '0 : r_bit + BIT_W'(1);
                end
            end else begin
                r_bit <= '0;
            end

            if (r_state == S_IDLE && bus.Load) begin
                r_hold <= bus.data_in;
            end

            // A Load arriving in the same cycle a frame launches keeps the
            // new word queued for the next frame.
            if (r_state == S_IDLE && bus.Load) begin
                r_loaded <= 1'b1;
            end else if (w_start) begin
                r_loaded <= 1'b0;
            end

            if (w_start) begin
                r_shift  <= r_hold;
                r_parity <= ^r_hold;
            end else if (r_state == S_DATA && w_wrap) begin
                r_shift  <= w_shift_next;
            end
        end
    end

    assign bus.serial_out  = r_serial_out;
    assign bus.Transmitted = w_transmitted;
    assign bus.busy        = w_busy;
endmodule

// File: tb/tb_serial_transmitter.sv
// tb_serial_transmitter
//   Drives two transmitters in lockstep (parity enabled / disabled) and
//   compares per-cycle traces of serial_out, Transmitted and busy against
//   frames built from the character format: start, data LSB first, optional
//   even parity, stop, each bit DIV cycles, done pulse right after.
//   Trace index t is cycles relative to the Load cycle L.
module tb_serial_transmitter;
    localparam int DW  = 8;
    localparam int DIV = 4;
    localparam int N   = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    serial_transmitter_if #(.DATA_W(DW)) bus0 ();
    serial_transmitter_if #(.DATA_W(DW)) bus1 ();

    serial_transmitter #(.DATA_W(DW), .DIV(DIV), .PARITY_EN(1)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    serial_transmitter #(.DATA_W(DW), .DIV(DIV), .PARITY_EN(0)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    int tests = 0;
    int fails = 0;

    logic o_ser [2][N];
    logic o_tx  [2][N];
    logic o_busy[2][N];
    logic e_ser [2][N];
    logic e_tx  [2][N];
    logic e_busy[2][N];

    task automatic drive(input logic ld, input logic tx, input logic [DW-1:0] d);
        bus0.Load = ld; bus0.Transmit = tx; bus0.data_in = d;
        bus1.Load = ld; bus1.Transmit = tx; bus1.data_in = d;
    endtask

    // Expected trace for one DUT: frame of bits expanded by DIV, starting at L+2.
    task automatic build_expect(input int k, input logic [DW-1:0] d, input int par_en);
        logic bits[$];
        int   ones;
        int   len;
        bits.delete();
        ones = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) begin
            bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (par_en != 0) bits.push_back(logic'(ones % 2));
        bits.push_back(1'b1);
        len = bits.size() * DIV;
        for (int t = 0; t < N; t++) begin
            e_ser[k][t]  = (t >= 2 && t < 2 + len) ? bits[(t - 2) / DIV] : 1'b1;
            e_tx[k][t]   = (t == 2 + len);
            e_busy[k][t] = (t >= 2 && t <= 2 + len);
        end
    endtask

    // Load at t=0, Transmit over [tx_from, drop_at), optional stray Load of FF.
    task automatic capture(input logic [DW-1:0] d, input int tx_from,
                           input int drop_at, input int glitch_at);
        logic            ld;
        logic [DW-1:0]   dd;
        for (int t = 0; t < N; t++) begin
            @(posedge clk);
            #2;
            ld = (t == 0) || (t == glitch_at);
            dd = (t == glitch_at) ? 8'hFF : ((t == 0) ? d : DW'($urandom));
            drive(ld, (t >= tx_from && t < drop_at), dd);
            #1;
            o_ser[0][t] = bus0.serial_out; o_tx[0][t] = bus0.Transmitted; o_busy[0][t] = bus0.busy;
            o_ser[1][t] = bus1.serial_out; o_tx[1][t] = bus1.Transmitted; o_busy[1][t] = bus1.busy;
        end
        drive(1'b0, 1'b0, '0);
    endtask

    task automatic test_reset;
        drive(1'b0, 1'b0, '0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        tests++;
        if (bus0.serial_out !== 1'b1) begin fails++; $display("FAIL reset_serial: got %b want 1", bus0.serial_out); end
        tests++;
        if (bus0.Transmitted !== 1'b0) begin fails++; $display("FAIL reset_transmitted: got %b want 0", bus0.Transmitted); end
        tests++;
        if (bus0.busy !== 1'b0 || bus1.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b/%b want 0/0", bus0.busy, bus1.busy); end
        rst = 1'b1;
    endtask

    task automatic test_transmit_no_load;
        int bad;
        bad = 0;
        for (int t = 0; t < 20; t++) begin
            @(posedge clk);
            #2;
            drive(1'b0, 1'b1, DW'($urandom));
            #1;
            if (bus0.serial_out !== 1'b1 || bus0.busy !== 1'b0 || bus0.Transmitted !== 1'b0 ||
                bus1.serial_out !== 1'b1 || bus1.busy !== 1'b0 || bus1.Transmitted !== 1'b0) bad++;
        end
        drive(1'b0, 1'b0, '0);
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL transmit_no_load: %0d active cycles, want 0", bad); end
    endtask

    task automatic test_basic_frame;
        int bad [2];
        capture(8'hA5, 1, N, -1);
        build_expect(0, 8'hA5, 1);
        build_expect(1, 8'hA5, 0);
        for (int k = 0; k < 2; k++) begin
            bad[k] = 0;
            for (int t = 0; t < N; t++)
                if (o_ser[k][t] !== e_ser[k][t] || o_tx[k][t] !== e_tx[k][t] || o_busy[k][t] !== e_busy[k][t]) bad[k]++;
            tests++;
            if (bad[k] !== 0) begin fails++; $display("FAIL basic_frame_dut%0d: %0d cycles differ, want 0", k, bad[k]); end
        end
        tests++;
        if (o_tx[0][46] !== 1'b1 || o_tx[0][45] !== 1'b0) begin
            fails++; $display("FAIL basic_done_at_46: got tx45=%b tx46=%b want 0,1", o_tx[0][45], o_tx[0][46]);
        end
    endtask

    task automatic test_parity;
        int bad [2];
        int pbad;
        capture(8'h07, 1, N, -1);
        build_expect(0, 8'h07, 1);
        build_expect(1, 8'h07, 0);
        for (int k = 0; k < 2; k++) begin
            bad[k] = 0;
            for (int t = 0; t < N; t++)
                if (o_ser[k][t] !== e_ser[k][t] || o_tx[k][t] !== e_tx[k][t] || o_busy[k][t] !== e_busy[k][t]) bad[k]++;
            tests++;
            if (bad[k] !== 0) begin fails++; $display("FAIL parity_frame_dut%0d: %0d cycles differ, want 0", k, bad[k]); end
        end
        pbad = 0;
        for (int t = 38; t <= 41; t++) if (o_ser[0][t] !== 1'b1) pbad++;
        tests++;
        if (pbad !== 0) begin fails++; $display("FAIL parity_bit_07: %0d of L+38..41 not 1", pbad); end
        tests++;
        if (o_tx[1][42] !== 1'b1 || o_busy[1][43] !== 1'b0) begin
            fails++; $display("FAIL noparity_done_at_42: got tx=%b busy43=%b want 1,0", o_tx[1][42], o_busy[1][43]);
        end
    endtask

    task automatic test_ignored_load;
        int bad;
        int late;
        capture(8'hA5, 1, N, 20);
        build_expect(0, 8'hA5, 1);
        bad = 0;
        for (int t = 0; t < N; t++)
            if (o_ser[0][t] !== e_ser[0][t] || o_tx[0][t] !== e_tx[0][t] || o_busy[0][t] !== e_busy[0][t]) bad++;
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL ignored_load_frame: %0d cycles differ, want 0", bad); end
        late = 0;
        for (int t = 47; t < N; t++) if (o_busy[0][t] !== 1'b0 || o_busy[1][t] !== 1'b0) late++;
        tests++;
        if (late !== 0) begin fails++; $display("FAIL ignored_load_no_restart: %0d busy cycles after DONE, want 0", late); end
    endtask

    task automatic test_transmit_drop;
        int bad;
        capture(8'hA5, 1, 10, -1);
        build_expect(0, 8'hA5, 1);
        bad = 0;
        for (int t = 0; t < N; t++)
            if (o_ser[0][t] !== e_ser[0][t] || o_tx[0][t] !== e_tx[0][t] || o_busy[0][t] !== e_busy[0][t]) bad++;
        tests++;
        if (bad !== 0) begin fails++; $display("FAIL transmit_drop_frame: %0d cycles differ, want 0", bad); end
        tests++;
        if (o_tx[0][46] !== 1'b1) begin fails++; $display("FAIL transmit_drop_done: got %b want 1", o_tx[0][46]); end
    endtask

    task automatic test_reset_mid_frame;
        int bad [2];
        for (int t = 0; t <= 20; t++) begin
            @(posedge clk);
            #2;
            drive(t == 0, t >= 1, (t == 0) ? 8'h5A : '0);
        end
        #1;
        rst = 1'b0;
        #1;
        tests++;
        if (bus0.serial_out !== 1'b1 || bus0.busy !== 1'b0 || bus0.Transmitted !== 1'b0 ||
            bus1.serial_out !== 1'b1 || bus1.busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_frame_async: got ser=%b busy=%b tx=%b want 1,0,0",
                     bus0.serial_out, bus0.busy, bus0.Transmitted);
        end
        drive(1'b0, 1'b0, '0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        capture(8'h3C, 1, N, -1);
        build_expect(0, 8'h3C, 1);
        build_expect(1, 8'h3C, 0);
        for (int k = 0; k < 2; k++) begin
            bad[k] = 0;
            for (int t = 0; t < N; t++)
                if (o_ser[k][t] !== e_ser[k][t] || o_tx[k][t] !== e_tx[k][t] || o_busy[k][t] !== e_busy[k][t]) bad[k]++;
            tests++;
            if (bad[k] !== 0) begin fails++; $display("FAIL reset_recovery_dut%0d: %0d cycles differ, want 0", k, bad[k]); end
        end
    endtask

    task automatic test_random;
        logic [DW-1:0] d;
        int tx_from;
        int drop_at;
        int bad [2];
        for (int r = 0; r < 8; r++) begin
            d       = DW'($urandom);
            tx_from = int'($urandom_range(0, 1));
            drop_at = int'($urandom_range(2, N));
            capture(d, tx_from, drop_at, (r % 2 == 0) ? int'($urandom_range(10, 40)) : -1);
            build_expect(0, d, 1);
            build_expect(1, d, 0);
            for (int k = 0; k < 2; k++) begin
                bad[k] = 0;
                for (int t = 0; t < N; t++)
                    if (o_ser[k][t] !== e_ser[k][t] || o_tx[k][t] !== e_tx[k][t] || o_busy[k][t] !== e_busy[k][t]) bad[k]++;
                tests++;
                if (bad[k] !== 0) begin
                    fails++;
                    $display("FAIL random_%0d_dut%0d data=%h txfrom=%0d drop=%0d: %0d cycles differ, want 0",
                             r, k, d, tx_from, drop_at, bad[k]);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        drive(1'b0, 1'b0, '0);
        test_reset;
        test_transmit_no_load;
        test_basic_frame;
        test_parity;
        test_ignored_load;
        test_transmit_drop;
        test_reset_mid_frame;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_transmitter.md
# serial_transmitter

Serializing back-end stage of the detect/collect/load/transmit link. It sits directly downstream of the link controller. On the controller's `Load` strobe it captures the collected parallel word. While `Transmit` is high it shifts out a framed serial character: start bit, data LSB-first, optional even parity, stop bit. It then returns a one-cycle `Transmitted` pulse so the controller goes back to detecting.

## Interface
- `DATA_W`, 8, width of the parallel word.
- `DIV`, 4, clock cycles per serial bit (≥2).
- `PARITY_EN`, 1, 1 = append even-parity bit, 0 = no parity bit.

- `clk`  in  1  single system clock, all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `Load`  in  1  one-cycle strobe from controller; capture `data_in`.
- `Transmit`  in  1  level from controller; high while it waits for `Transmitted`.
- `data_in`  in  DATA_W  parallel word from the collect stage.
- `Transmitted`  out  1  one-cycle done pulse to controller.
- `serial_out`  out  1  serial line, idle high, registered.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- Holding register `hold[DATA_W-1:0]` and flag `loaded`.
  - `Load`=1 in IDLE: `hold`←`data_in`, `loaded`←1.
  - `Load` in any other state is ignored; `hold` is unchanged.
- FSM states and transitions:
  - IDLE: go to START when `Transmit`=1 and `loaded`=1; otherwise stay.
  - START: `serial_out`=0 for DIV cycles. On entry, shift register ← `hold`, parity ← ^`hold`, `loaded`←0.
  - DATA: DATA_W bits, LSB first, each held DIV cycles. Go to PARITY if PARITY_EN, else STOP.
  - PARITY: `serial_out`=even parity (XOR of the data bits) for DIV cycles.
  - STOP: `serial_out`=1 for DIV cycles, then DONE.
  - DONE: one cycle, `Transmitted`=1, `serial_out`=1; unconditionally to IDLE.
- Counters:
  - Baud counter counts 0..DIV-1 and wraps; the bit advances on the wrap.
  - Bit counter counts 0..DATA_W-1.
  - Counter widths are `$clog2` of the maximum count; the `$clog2` argument is ≥1.
- `Transmitted` is decoded from state DONE only; it is never asserted in any other state.
- `Transmit` deasserting mid-frame does not abort; the frame completes and DONE still pulses.
- `Transmit`=1 in DONE does not restart a frame; a new frame needs IDLE with `loaded`=1.
- `Transmit`=1 in IDLE with `loaded`=0: stay IDLE, `serial_out`=1.
- Same-cycle `Load` and `Transmit` in IDLE with `loaded`=0: `Load` is captured; START follows one cycle later.
- Reset (any time, including mid-frame):
  - Immediate IDLE; counters=0; `hold`=0; `loaded`=0.
  - Outputs: `serial_out`=1, `Transmitted`=0, `busy`=0.

## Timing
- Let cycle L be the cycle with `Load`=1. The controller raises `Transmit` at L+1.
- Start bit occupies L+2..L+1+DIV.
- Frame length is (2+DATA_W+PARITY_EN)·DIV cycles.
- `Transmitted` is high in cycle L+2+(2+DATA_W+PARITY_EN)·DIV. With defaults this is L+46.
- The controller samples `Transmitted` on the edge closing DONE. Both blocks are idle/detecting on the next cycle.
- `serial_out` changes only on clock edges (glitch-free line).

## Test plan
- Basic frame (defaults): `Load` with `data_in`=8'hA5 at L, `Transmit` high from L+1.
  - Required: `serial_out` sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 4 cycles, starting at L+2.
  - Required: `Transmitted` high only at L+46; `busy` high over L+2..L+46.
- Parity odd-weight (defaults): `data_in`=8'h07.
  - Required: parity bit = 1 at L+38..L+41.
  - Required: frame with PARITY_EN=0 is 40 cycles; `Transmitted` at L+42.
- Ignored load: during DATA, pulse `Load` with 8'hFF.
  - Required: frame still carries 8'hA5.
  - Required: after DONE with `Transmit` held, no new frame starts (`loaded`=0).
- Transmit without load: `Transmit`=1 for 20 cycles after reset, no `Load`.
  - Required: `serial_out`=1, `busy`=0, `Transmitted`=0 throughout.
- Reset mid-frame: drive `rst`=0 asynchronously at L+20.
  - Required: `serial_out`=1, `busy`=0, `Transmitted`=0 immediately.
  - Required: after release, a fresh `Load`(8'h3C)+`Transmit` gives a correct full frame.
- Transmit drop: deassert `Transmit` at L+10.
  - Required: frame completes unchanged; `Transmitted` still pulses at L+46.
